// File: rtl/det3_seq.sv
// det3_seq: sequential 3x3 signed determinant by cofactor expansion along row 0.
// One 2x2 minor and its cofactor product per cycle (MINOR0..MINOR2), then DONE
// publishes det/ovf and a one-cycle done pulse on the following cycle.
// Optional feature: define DET3_MINOR_OVF_EN to also flag ovf when any 2x2
// minor falls outside the ELEM_W signed range.

// One cofactor term: coef * (x0*x1 - y0*y1), optionally negated.
module det3_cofactor #(
  parameter int W = 8
) (
  input  logic signed [W-1:0] x0,
  input  logic signed [W-1:0] x1,
  input  logic signed [W-1:0] y0,
  input  logic signed [W-1:0] y1,
  input  logic signed [W-1:0] coef,
  input  logic                neg,
  output logic signed [3*W:0] cof
`ifdef DET3_MINOR_OVF_EN
  ,
  output logic                minor_ovf
`endif
);
  localparam int PW = 2*W;
  localparam int MW = 2*W + 1;
  localparam int CW = 3*W + 1;

  logic signed [PW-1:0] p0, p1;
  logic signed [MW-1:0] minor;
  logic signed [CW-1:0] prod;

  // Full-precision minor and cofactor product; widths chosen so nothing wraps.
  always_comb begin
    p0    = PW'(x0) * PW'(x1);
    p1    = PW'(y0) * PW'(y1);
    minor = MW'(p0) - MW'(p1);
    prod  = CW'(coef) * CW'(minor);
    cof   = neg ? -prod : prod;
  end

`ifdef DET3_MINOR_OVF_EN
  // Minor fits ELEM_W signed iff all bits above the sign bit equal the sign.
  always_comb begin
    minor_ovf = !((&minor[MW-1:W-1]) || !(|minor[MW-1:W-1]));
  end
`endif
endmodule

module det3_seq #(
  parameter int ELEM_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [9*ELEM_W-1:0] m,
  output logic                busy,
  output logic                done,
  output logic [ELEM_W-1:0]   det,
  output logic                ovf
);
  localparam int CW = 3*ELEM_W + 1;
  localparam int AW = 3*ELEM_W + 3;

  typedef enum logic [2:0] {IDLE, MINOR0, MINOR1, MINOR2, DONE} state_t;

  state_t state, nstate;

  // a[8-(3r+c)] holds a[r][c]; this matches the bit layout of m directly.
  logic [8:0][ELEM_W-1:0] a;
  logic signed [AW-1:0]   acc;

  logic ld, acc_en, fin;
  logic signed [ELEM_W-1:0] x0, x1, y0, y1, coef;
  logic                     neg;
  logic signed [CW-1:0]     cof;
  logic                     acc_ovf;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end

  // Next-state: start only matters in IDLE, everything else is a fixed walk.
  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (start) nstate = MINOR0;
      MINOR0:  nstate = MINOR1;
      MINOR1:  nstate = MINOR2;
      MINOR2:  nstate = DONE;
      DONE:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // FSM outputs: busy flag and datapath strobes.
  always_comb begin
    busy   = (state != IDLE);
    ld     = (state == IDLE) && start;
    acc_en = (state == MINOR0) || (state == MINOR1) || (state == MINOR2);
    fin    = (state == DONE);
  end

  // Operand select for the current minor (x0*x1 - y0*y1) and its row-0 coefficient.
  always_comb begin
    x0 = '0; x1 = '0; y0 = '0; y1 = '0; coef = '0; neg = 1'b0;
    case (state)
      MINOR0: begin  // +a00 * (a11*a22 - a12*a21)
        x0 = $signed(a[4]); x1 = $signed(a[0]);
        y0 = $signed(a[3]); y1 = $signed(a[1]);
        coef = $signed(a[8]); neg = 1'b0;
      end
      MINOR1: begin  // -a01 * (a10*a22 - a12*a20)
        x0 = $signed(a[5]); x1 = $signed(a[0]);
        y0 = $signed(a[3]); y1 = $signed(a[2]);
        coef = $signed(a[7]); neg = 1'b1;
      end
      MINOR2: begin  // +a02 * (a10*a21 - a11*a20)
        x0 = $signed(a[5]); x1 = $signed(a[1]);
        y0 = $signed(a[4]); y1 = $signed(a[2]);
        coef = $signed(a[6]); neg = 1'b0;
      end
      default: ;
    endcase
  end

`ifdef DET3_MINOR_OVF_EN
  logic minor_ovf;
  logic movf;
`endif

  det3_cofactor #(.W(ELEM_W)) u_cof (
    .x0        (x0),
    .x1        (x1),
    .y0        (y0),
    .y1        (y1),
    .coef      (coef),
    .neg       (neg),
    .cof       (cof)
`ifdef DET3_MINOR_OVF_EN
    ,
    .minor_ovf (minor_ovf)
`endif
  );

  // Capture the matrix on accept (isolates result from later m changes) and accumulate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a   <= '0;
      acc <= '0;
    end else if (ld) begin
      a   <= m;
      acc <= '0;
    end else if (acc_en) begin
      acc <= acc + AW'(cof);
    end
  end

`ifdef DET3_MINOR_OVF_EN
  // Sticky flag: any minor that would not survive a truncating ELEM_W stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      movf <= 1'b0;
    else if (ld)     movf <= 1'b0;
    else if (acc_en) movf <= movf | minor_ovf;
  end
`endif

  // Accumulator fits ELEM_W signed iff its upper bits are a pure sign extension.
  always_comb begin
    acc_ovf = !((&acc[AW-1:ELEM_W-1]) || !(|acc[AW-1:ELEM_W-1]));
  end

  // Publish result on DONE; det/ovf hold until the next completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done <= 1'b0;
      det  <= '0;
      ovf  <= 1'b0;
    end else begin
      done <= fin;
      if (fin) begin
        det <= acc[ELEM_W-1:0];
`ifdef DET3_MINOR_OVF_EN
        ovf <= acc_ovf | movf;
`else
        ovf <= acc_ovf;
`endif
      end
    end
  end
endmodule

// File: tb/tb_det3_seq.sv
// Scoreboard bench for det3_seq: the driver pushes hand-computed results at
// issue time, a negedge monitor pops on done and checks value, ovf and cycle.
module tb_det3_seq;
  localparam int NV = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [71:0] m = '0;
  logic        busy, done, ovf;
  logic [7:0]  det;

  det3_seq #(.ELEM_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .m     (m),
    .busy  (busy),
    .done  (done),
    .det   (det),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] det;
    logic       ovf;
    int         cyc;
    int         id;
  } exp_t;

  exp_t       q[$];
  int         vm[NV][9];
  logic [7:0] edet[NV];
  logic       eovf[NV];

  int   total = 0;
  int   bad = 0;
  int   brun = 0;
  logic [7:0] last_det = '0;
  logic       last_ovf = 1'b0;
  bit   end_req = 0;
  bit   end_ack = 0;

  function automatic logic [71:0] pack(input int i);
    logic [71:0] r;
    r = '0;
    for (int k = 0; k < 9; k++) r[(8-k)*8 +: 8] = 8'(vm[i][k]);
    return r;
  endfunction

  task automatic push(input int i, input int c);
    exp_t e;
    e.det = edet[i];
    e.ovf = eovf[i];
    e.cyc = c;
    e.id  = i;
    q.push_back(e);
  endtask

  // Single operation; m is scrambled right after acceptance.
  task automatic run_one(input int i);
    @(posedge clk); #2;
    m = pack(i); start = 1'b1;
    push(i, cyc + 5);
    @(posedge clk); #2;
    start = 1'b0; m = pack((i + 1) % NV);
    repeat (6) @(posedge clk);
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || det !== 8'h00 || ovf !== 1'b0) begin
        bad++;
        $display("FAIL reset_state: busy=%b done=%b det=%h ovf=%b, want 0 0 00 0", busy, done, det, ovf);
      end
      last_det = '0; last_ovf = 1'b0; brun = 0;
    end else begin
      if (busy === 1'b1) brun++;
      else if (brun != 0) begin
        total++;
        if (brun != 4) begin
          bad++;
          $display("FAIL busy_len: got %0d cycles, want 4", brun);
        end
        brun = 0;
      end
      if (done === 1'b1) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_done: det=%h ovf=%b at cyc %0d", det, ovf, cyc);
        end else begin
          e = q.pop_front();
          if (det !== e.det || ovf !== e.ovf || cyc != e.cyc) begin
            bad++;
            $display("FAIL result vec%0d: det=%h ovf=%b cyc=%0d, want det=%h ovf=%b cyc=%0d",
                     e.id, det, ovf, cyc, e.det, e.ovf, e.cyc);
          end
          last_det = e.det; last_ovf = e.ovf;
        end
      end else begin
        total++;
        if (det !== last_det || ovf !== last_ovf) begin
          bad++;
          $display("FAIL hold: det=%h ovf=%b, want det=%h ovf=%b", det, ovf, last_det, last_ovf);
        end
      end
      if (end_req && !end_ack) begin
        total++;
        if (q.size() != 0) begin
          bad++;
          $display("FAIL drain: %0d results outstanding, want 0", q.size());
        end
        end_ack = 1;
      end
    end
  end

  initial begin
    // Vectors (row-major) with hand-computed det (8-bit) and ovf.
    vm[0] = '{1, 0, 0, 0, 1, 0, 0, 0, 1};          edet[0] = 8'h01; eovf[0] = 1'b0;
    vm[1] = '{1, 2, 3, 4, 5, 6, 7, 8, 9};          edet[1] = 8'h00; eovf[1] = 1'b0;
    vm[2] = '{-128, 0, 0, 0, 1, 0, 0, 0, 1};       edet[2] = 8'h80; eovf[2] = 1'b0;
    vm[3] = '{10, 0, 0, 0, 10, 0, 0, 0, 10};       edet[3] = 8'hE8; eovf[3] = 1'b1;
    vm[4] = '{0, 1, 0, 0, 20, 0, 1, 0, 20};        edet[4] = 8'h00;
`ifdef DET3_MINOR_OVF_EN
    eovf[4] = 1'b1;
`else
    eovf[4] = 1'b0;
`endif
    vm[5] = '{1, 2, 3, 0, 1, 4, 5, 6, 0};          edet[5] = 8'h01; eovf[5] = 1'b0;
    vm[6] = '{127, 0, 0, 0, 1, 0, 0, 0, 1};        edet[6] = 8'h7F; eovf[6] = 1'b0;
    vm[7] = '{-1, 0, 0, 0, -128, 0, 0, 0, 1};      edet[7] = 8'h80; eovf[7] = 1'b1;
    vm[8] = '{-128, -128, -128, -128, -128, -128, -128, -128, -128};
                                                   edet[8] = 8'h00; eovf[8] = 1'b0;
    vm[9] = '{2, 0, 0, 0, 3, 0, 0, 0, 4};          edet[9] = 8'h18; eovf[9] = 1'b0;

    // Power-on reset.
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    for (int i = 0; i < NV; i++) run_one(i);

    // Abort in MINOR1: no done may follow, outputs clear immediately.
    @(posedge clk); #2;
    m = pack(3); start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1; start = 1'b1; m = pack(9);
    push(9, cyc + 5);
    @(posedge clk); #2;
    start = 1'b0;
    repeat (6) @(posedge clk);

    // start held high, m changing every cycle: accepts at offsets 0, 5, 10.
    for (int j = 0; j < 15; j++) begin
      @(posedge clk); #2;
      start = 1'b1;
      m = pack((j + 2) % NV);
      if (j % 5 == 0) push((j + 2) % NV, cyc + 5);
    end
    @(posedge clk); #2;
    start = 1'b0;

    for (int t = 0; t < 50 && q.size() != 0; t++) @(posedge clk);
    repeat (3) @(posedge clk);
    end_req = 1;
    repeat (2) @(negedge clk);
    if (!end_ack) begin
      bad++;
      total++;
      $display("FAIL end_handshake: monitor did not respond, want ack");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/det3_seq.md
DET3_SEQ -- requirements
Module: det3_seq

Interface
REQ-001 Parameter ELEM_W, default 8: signed element width in bits; also the width of the det output.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 m  input  9*ELEM_W  3x3 signed matrix, row-major. Element a[r][c] occupies bits [(8-(3r+c))*ELEM_W +: ELEM_W], so a00 is in the MSBs.
REQ-006 busy  output  1  high whenever state is not IDLE.
REQ-007 done  output  1  one-cycle pulse when det/ovf are updated.
REQ-008 det  output  ELEM_W  signed determinant, truncated to ELEM_W LSBs.
REQ-009 ovf  output  1  overflow flag for det.

Function
REQ-010 The block SHALL compute det = a00*M0 - a01*M1 + a02*M2 by cofactor expansion along row 0, with M0=a11*a22-a12*a21, M1=a10*a22-a12*a20, M2=a10*a21-a11*a20.
REQ-011 FSM states SHALL be IDLE, MINOR0, MINOR1, MINOR2, DONE; transitions are IDLE->MINOR0 on start, MINOR0->MINOR1->MINOR2->DONE unconditionally, then DONE->IDLE.
REQ-012 On accepting start in IDLE, the block SHALL register m into an internal copy and clear the accumulator; later changes on m SHALL NOT affect the result.
REQ-013 In MINORk, the block SHALL compute one 2x2 minor and its signed cofactor product, and add it to the accumulator; exactly one minor per cycle.
REQ-014 Arithmetic widths: products 2*ELEM_W bits; minors 2*ELEM_W+1 bits; cofactor products 3*ELEM_W+1 bits; accumulator 3*ELEM_W+3 bits, all signed, with no internal wrap.
REQ-015 On the DONE cycle, det SHALL receive accumulator[ELEM_W-1:0], and ovf SHALL be set if the accumulator lies outside [-2^(ELEM_W-1), 2^(ELEM_W-1)-1].
REQ-016 Latency: with start sampled at edge T, done SHALL be high during the cycle after edge T+4, for exactly one cycle.
REQ-017 start while busy=1 (including in DONE) SHALL be ignored and not queued; the next start is accepted in the cycle after done; maximum throughput is one result per 5 cycles.
REQ-018 det and ovf SHALL hold their value between done pulses.

Reset
REQ-019 rst_n=0 SHALL immediately force state IDLE, busy=0, done=0, det=0, ovf=0, accumulator=0 and internal matrix copy=0, regardless of clock.
REQ-020 A reset asserted mid-operation SHALL abort the operation; no done pulse SHALL follow it.
REQ-021 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted.

Configuration
REQ-022 Macro DET3_MINOR_OVF_EN defined: ovf SHALL additionally be set if any of M0, M1, M2 lies outside the ELEM_W signed range, matching a chained 2x2 stage that truncates minors.
REQ-023 Macro DET3_MINOR_OVF_EN undefined: ovf SHALL depend only on the final accumulator (REQ-015), and no minor-range logic SHALL be synthesised.

Verification
REQ-024 Identity matrix, start pulse -> after 4 cycles done=1, det=1, ovf=0; busy high for 4 cycles.
REQ-025 Rows [1,2,3],[4,5,6],[7,8,9] -> det=0, ovf=0; rows [-128,0,0],[0,1,0],[0,0,1] -> det=-128 (0x80), ovf=0.
REQ-026 diag(10,10,10) -> accumulator 1000, det=0xE8 (-24), ovf=1.
REQ-027 Rows [0,1,0],[0,20,0],[1,0,20] -> det=0; ovf=1 with DET3_MINOR_OVF_EN defined (M0=400), ovf=0 without it.
REQ-028 Start accepted, rst_n pulsed low during MINOR1 -> busy/done/det/ovf=0 at once, no done pulse; a new start after release gives a correct result.
REQ-029 start held high continuously with m changing each cycle -> results every 5 cycles, each matching the m value sampled at acceptance; starts during busy have no effect.
